// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - load/store memory-port controller for a word-wide synchronous SRAM
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   req_*                core request (valid/we/size/signed/addr/wdata), sampled only in IDLE
//   req_ready, align_err one-cycle completion pulse; align_err marks a rejected request
//   rsp_rdata            aligned/extended load result, held until the next successful load
//   mem_*                SRAM cycle: cs/we/oe strobes, word address, byte enables, write/read data
module mem_port_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        align_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        align_err_q, align_err_d;
  logic        mem_cs_q, mem_cs_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_oe_q, mem_oe_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  // Access shape kept for the load-data alignment at the end of ACCESS.
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;

  logic        illegal;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign illegal = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    align_err_d = 1'b0;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            // Rejected without any SRAM strobe; completion is reported next cycle.
            state_d     = DONE;
            req_ready_d = 1'b1;
            align_err_d = 1'b1;
          end else begin
            state_d    = ACCESS;
            cnt_d      = 4'(WAIT_STATES);
            mem_cs_d   = 1'b1;
            mem_we_d   = req_we;
            mem_oe_d   = ~req_we;
            mem_addr_d = {req_addr[31:2], 2'b00};
            size_d     = req_size;
            signed_d   = req_signed;
            off_d      = req_addr[1:0];
            unique case (req_size)
              2'b00: begin
                mem_be_d    = 4'b0001 << req_addr[1:0];
                mem_wdata_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                mem_be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = req_wdata;
              end
            endcase
            if (!req_we) begin
              mem_wdata_d = 32'h0;
            end
          end
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final SRAM cycle: mem_rdata is valid now.
          if (!mem_we_q) begin
            unique case (size_q)
              2'b00:   rsp_rdata_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
              2'b01:   rsp_rdata_d = {{16{signed_q & rd_half[15]}}, rd_half};
              default: rsp_rdata_d = mem_rdata;
            endcase
          end
          mem_cs_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_oe_d    = 1'b0;
          mem_be_d    = 4'b0000;
          state_d     = DONE;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      align_err_q <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      align_err_q <= align_err_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
    end
  end

  assign req_ready = req_ready_q;
  assign align_err = align_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
